// File: rtl/tof_trigger_gen.sv
// Trigger generator and echo edge detector for a time-of-flight sensor.
// Optional glitch filter on the synchronized echo: define TOF_ECHO_FILTER_EN.
module tof_trigger_gen #(
    parameter int TRIG_WIDTH = 500,
    parameter int PERIOD     = 3_000_000,
    parameter int TIMEOUT    = 1_500_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic echo_in,
    output logic trig_out,
    output logic start_flag,
    output logic end_flag,
    output logic timeout_flag,
    output logic busy
);

    localparam int PW  = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
    localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0]  P_LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0]  TR_LAST = PW'(TRIG_WIDTH - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        WAIT_FALL,
        HOLDOFF
    } state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  pcnt, pcnt_nx;
    logic [TOW-1:0] tcnt, tcnt_nx;
    logic           start_d, end_d, to_d;

    logic sync1, sync2, echo_q, echo_dly, rise_q, fall_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= echo_in;
            sync2 <= sync1;
        end
    end

`ifdef TOF_ECHO_FILTER_EN
    logic [1:0] flt_cnt;
    logic       echo_flt;

    // Filtered level follows sync2 only after the new value is seen on 4 consecutive edges.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            flt_cnt  <= '0;
            echo_flt <= 1'b0;
        end else if (sync2 != echo_flt) begin
            if (flt_cnt == 2'd3) begin
                echo_flt <= sync2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 2'd1;
            end
        end else begin
            flt_cnt <= '0;
        end
    end

    assign echo_q = echo_flt;
`else
    assign echo_q = sync2;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            echo_dly <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            echo_dly <= echo_q;
            rise_q   <= echo_q & ~echo_dly;
            fall_q   <= ~echo_q & echo_dly;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            pcnt  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            tcnt  <= tcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        tcnt_nx  = tcnt;
        start_d  = 1'b0;
        end_d    = 1'b0;
        to_d     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = TRIG;
                    pcnt_nx  = '0;
                end
            end
            TRIG: begin
                pcnt_nx = pcnt + 1'b1;
                if (pcnt == TR_LAST) begin
                    state_nx = WAIT_RISE;
                    tcnt_nx  = '0;
                end
            end
            WAIT_RISE: begin
                pcnt_nx = pcnt + 1'b1;
                tcnt_nx = tcnt + 1'b1;
                // Timeout takes priority over a coincident rise.
                if (tcnt == TO_LAST) begin
                    end_d    = 1'b1;
                    to_d     = 1'b1;
                    state_nx = HOLDOFF;
                end else if (rise_q) begin
                    start_d  = 1'b1;
                    state_nx = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                pcnt_nx = pcnt + 1'b1;
                tcnt_nx = tcnt + 1'b1;
                // A coincident fall counts as a normal end.
                if (fall_q) begin
                    end_d    = 1'b1;
                    state_nx = HOLDOFF;
                end else if (tcnt == TO_LAST) begin
                    end_d    = 1'b1;
                    to_d     = 1'b1;
                    state_nx = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (pcnt == P_LAST) begin
                    pcnt_nx  = '0;
                    state_nx = en ? TRIG : IDLE;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                pcnt_nx  = '0;
                tcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            trig_out     <= 1'b0;
            start_flag   <= 1'b0;
            end_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            busy         <= 1'b0;
        end else begin
            trig_out     <= (state == TRIG);
            start_flag   <= start_d;
            end_flag     <= end_d;
            timeout_flag <= to_d;
            busy         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_tof_trigger_gen.sv
// Directed bench for tof_trigger_gen with TRIG_WIDTH=4, PERIOD=100, TIMEOUT=50.
module tb_tof_trigger_gen;

    localparam int TW  = 4;
    localparam int PER = 100;
    localparam int TO  = 50;
`ifdef TOF_ECHO_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic en      = 1'b0;
    logic echo_in = 1'b0;
    logic trig_out, start_flag, end_flag, timeout_flag, busy;

    tof_trigger_gen #(
        .TRIG_WIDTH(TW),
        .PERIOD    (PER),
        .TIMEOUT   (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .start_flag  (start_flag),
        .end_flag    (end_flag),
        .timeout_flag(timeout_flag),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int   trig_rise_q[$];
    int   trig_fall_q[$];
    int   start_q[$];
    int   end_q[$];
    int   to_q[$];
    int   overlap_cnt = 0;
    logic trig_prev = 1'b0;

    // Event recorder, sampled mid-cycle; cyc equals the index of the last active edge.
    always @(negedge sys_clk) begin
        if (trig_out && !trig_prev) trig_rise_q.push_back(cyc);
        if (!trig_out && trig_prev) trig_fall_q.push_back(cyc);
        trig_prev <= trig_out;
        if (start_flag) start_q.push_back(cyc);
        if (end_flag) begin
            end_q.push_back(cyc);
            to_q.push_back(int'(timeout_flag));
        end
        if (start_flag && end_flag) overlap_cnt++;
        if (timeout_flag && !end_flag) overlap_cnt++;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_log();
        trig_rise_q.delete();
        trig_fall_q.delete();
        start_q.delete();
        end_q.delete();
        to_q.delete();
        overlap_cnt = 0;
    endtask

    task automatic do_reset(input logic lvl);
        sys_rst = 1'b1;
        en      = 1'b0;
        echo_in = lvl;
        step(3);
        check("rst_outs", int'({trig_out, start_flag, end_flag, timeout_flag, busy}), 0);
        sys_rst = 1'b0;
        step(1);
        clear_log();
    endtask

    int k0, k1, busy_lo;

    initial begin
        // Trigger timing, repetition, busy, and a no-echo timeout
        do_reset(1'b0);
        en = 1'b1;
        k0 = cyc;
        busy_lo = 0;
        repeat (110) begin
            step(1);
            if (!busy) busy_lo++;
        end
        check("trig_rise0", qat(trig_rise_q, 0), k0 + 2);
        check("trig_fall0", qat(trig_fall_q, 0), k0 + 2 + TW);
        check("trig_rise1", qat(trig_rise_q, 1), k0 + 2 + PER);
        check("busy_low_cnt", busy_lo, 0);
        check("noecho_starts", start_q.size(), 0);
        check("noecho_end", qat(end_q, 0), k0 + 1 + TW + TO);
        check("noecho_to", qat(to_q, 0), 1);
        check("noecho_overlap", overlap_cnt, 0);

        // Normal 20-cycle echo, with en dropped while waiting for the fall
        do_reset(1'b0);
        en = 1'b1;
        k0 = cyc;
        step(16);
        echo_in = 1'b1;
        step(9);
        en = 1'b0;
        step(11);
        echo_in = 1'b0;
        step(64);
        check("dis_busy_c100", int'(busy), 1);
        step(1);
        check("dis_busy_c101", int'(busy), 0);
        step(110);
        check("echo_start", qat(start_q, 0), k0 + 17 + LAT);
        check("echo_end", qat(end_q, 0), k0 + 37 + LAT);
        check("echo_width", qat(end_q, 0) - qat(start_q, 0), 20);
        check("echo_to", qat(to_q, 0), 0);
        check("echo_nstart", start_q.size(), 1);
        check("echo_nend", end_q.size(), 1);
        check("dis_ntrig", trig_rise_q.size(), 1);
        check("echo_overlap", overlap_cnt, 0);

        // Echo already high before and through the trigger
        do_reset(1'b1);
        step(10);
        en = 1'b1;
        k0 = cyc;
        step(70);
        check("stuck_starts", start_q.size(), 0);
        check("stuck_end", qat(end_q, 0), k0 + 1 + TW + TO);
        check("stuck_to", qat(to_q, 0), 1);

        // Two-cycle echo pulse
        do_reset(1'b0);
        en = 1'b1;
        k0 = cyc;
        step(16);
        echo_in = 1'b1;
        step(2);
        echo_in = 1'b0;
        step(60);
`ifdef TOF_ECHO_FILTER_EN
        check("glitch_starts", start_q.size(), 0);
        check("glitch_end", qat(end_q, 0), k0 + 1 + TW + TO);
        check("glitch_to", qat(to_q, 0), 1);
`else
        check("glitch_start", qat(start_q, 0), k0 + 20);
        check("glitch_end", qat(end_q, 0), k0 + 22);
        check("glitch_to", qat(to_q, 0), 0);
`endif

        // Reset asserted during the trigger pulse, then restart
        do_reset(1'b0);
        en = 1'b1;
        k0 = cyc;
        step(3);
        check("trig_before_rst", int'(trig_out), 1);
        sys_rst = 1'b1;
        #1;
        check("trig_async_rst", int'(trig_out), 0);
        check("busy_async_rst", int'(busy), 0);
        step(2);
        sys_rst = 1'b0;
        k1 = cyc;
        clear_log();
        step(8);
        check("restart_trig", qat(trig_rise_q, 0), k1 + 2);
        check("restart_fall", qat(trig_fall_q, 0), k1 + 2 + TW);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tof_trigger_gen.md
# tof_trigger_gen

- Generates the periodic trigger pulse for an ultrasonic/time-of-flight sensor.
- Watches the sensor's echo line and produces the single-cycle `start_flag` / `end_flag` pulses consumed by the downstream pulse-width counter.
- Sits between the sensor pins and the measurement counter, in the same `sys_clk` domain; it is the producing end of the start/end flag interface.

## Interface
Parameters:
- `TRIG_WIDTH`, 500 — trigger high time in `sys_clk` cycles (10 µs @ 50 MHz); ≥1.
- `PERIOD`, 3_000_000 — trigger-to-trigger interval in cycles; must exceed `TRIG_WIDTH + TIMEOUT + 8`.
- `TIMEOUT`, 1_500_000 — maximum cycles spent waiting for echo (rise plus fall) after the trigger ends.

Ports:
- `sys_clk` in 1 — single clock.
- `sys_rst` in 1 — asynchronous, active-high reset.
- `en` in 1 — enables measurement cycles; level.
- `echo_in` in 1 — raw asynchronous echo from the sensor.
- `trig_out` out 1 — trigger to the sensor, registered.
- `start_flag` out 1 — one-cycle pulse on the accepted echo rising edge.
- `end_flag` out 1 — one-cycle pulse on the accepted echo falling edge or on timeout.
- `timeout_flag` out 1 — one-cycle pulse, coincident with `end_flag`, when the end is caused by timeout.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **Echo conditioning**
  - `echo_in` passes through a 2-FF synchronizer, then one delay register.
  - rise = sync & ~delayed; fall = ~sync & delayed.
- **FSM states:** IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF.
- **IDLE:** if `en`=1, go to TRIG and clear the period counter.
- **TRIG:** `trig_out`=1 for exactly `TRIG_WIDTH` cycles, then go to WAIT_RISE and clear the timeout counter.
- **WAIT_RISE:**
  - on rise: pulse `start_flag`, go to WAIT_FALL.
  - on timeout counter = `TIMEOUT-1`: pulse `end_flag` and `timeout_flag`, go to HOLDOFF.
- **WAIT_FALL:**
  - on fall: pulse `end_flag`, go to HOLDOFF.
  - on timeout: same as in WAIT_RISE. The timeout counter is not cleared between WAIT_RISE and WAIT_FALL.
- **HOLDOFF:** when the period counter = `PERIOD-1`:
  - if `en`=1, go to TRIG and clear the period counter;
  - otherwise go to IDLE.
- **Period counter**
  - Counts every cycle from TRIG entry.
  - Width `$clog2(PERIOD)`; never wraps within a cycle.
- **Timeout counter**
  - Width `$clog2(TIMEOUT)`.
  - Counts only in WAIT_RISE and WAIT_FALL.
- **Edges outside their state are ignored:**
  - a rise during TRIG, WAIT_FALL or HOLDOFF;
  - a fall during WAIT_RISE;
  - an echo already high on WAIT_RISE entry produces no start.
- **Simultaneous events**
  - Fall and timeout in the same cycle: treated as a normal end (`timeout_flag`=0).
  - Rise and timeout in the same cycle: timeout wins and `start_flag` is not asserted.
- **Deasserting `en` mid-cycle:** the current measurement completes; no new trigger is issued; return to IDLE at the end of the period.
- **Flag guarantees**
  - `start_flag` and `end_flag` are never high in the same cycle.
  - Every `start_flag` is followed by exactly one `end_flag` before the next trigger.

## Timing
- **Reset values:** FSM=IDLE, counters=0, synchronizer and delay registers=0, all outputs=0.
- **Reset mid-operation:** all outputs drop asynchronously; the block restarts from IDLE after reset release.
- **Trigger start:** `en` sampled high in IDLE at edge N → `trig_out`=1 from edge N+1 through edge N+`TRIG_WIDTH`.
- **Trigger repetition:** consecutive `trig_out` rising edges are exactly `PERIOD` cycles apart while `en`=1.
- **Echo-to-flag latency:** echo edge first sampled at edge M → flag high during the cycle after edge M+3 (2 sync + 1 edge-detect + 1 output register).
- **Measured width:** the start-to-end flag spacing equals the echo high width in cycles (±1 from sampling).
- **All outputs are registered.**

## Configuration
- **`TOF_ECHO_FILTER_EN` defined**
  - Inserts a glitch filter after the synchronizer: the filtered echo changes only after the synchronized echo holds its new value for 4 consecutive cycles.
  - Pulses shorter than 4 cycles are rejected.
  - Echo-to-flag latency becomes 7 cycles.
- **Undefined:** no filter; latency 3 cycles; any pulse of 1 or more cycles is accepted.

## Test plan
Bench parameters for all scenarios: `TRIG_WIDTH`=4, `PERIOD`=100, `TIMEOUT`=50.

- **Reset and trigger:** assert `sys_rst`, release, set `en`=1 → `trig_out` high for exactly 4 cycles; the next `trig_out` rise comes 100 cycles later; `busy`=1 throughout.
- **Normal echo:** raise `echo_in` 10 cycles after the trigger falls, hold it 20 cycles →
  - `start_flag` 1 cycle wide, 3 cycles after the rise;
  - `end_flag` 20 cycles after `start_flag`;
  - `timeout_flag`=0.
- **No echo:** leave `echo_in` low → `end_flag` and `timeout_flag` pulse together 50 cycles after WAIT_RISE entry; no `start_flag`.
- **Echo stuck high:** hold `echo_in` high before and through the trigger → no `start_flag`; timeout end at 50 cycles.
- **Disable and reset mid-operation:**
  - drop `en` during WAIT_FALL → `end_flag` still occurs, no further trigger, `busy`=0 at cycle 100;
  - assert `sys_rst` in TRIG → `trig_out`=0 immediately.
- **Filter (`TOF_ECHO_FILTER_EN`):**
  - a 2-cycle echo glitch produces no flags;
  - a 20-cycle echo produces `start_flag` at latency 7 and flag spacing of 20.
